// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is written at the end of a fixed busy window, and busy/stall go to the hazard unit.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  op_e  req_op;
  logic req_long;

  assign req_op   = op_e'(op);
  assign req_long = req_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};

  // The counter alone encodes the busy window: it is non-zero from E0 up to E_N.
  assign busy  = (cnt_q != '0);
  assign stall = busy | (start & req_long);
  assign hi    = hi_q;
  assign lo    = lo_q;

  // Result datapath, evaluated from the operands latched at E0.
  logic        signed_op;
  logic        a_neg, b_neg;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;
  logic        res_valid;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    signed_op = (op_q == OP_MULT) || (op_q == OP_DIV);
    a_ext     = signed_op ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    b_ext     = signed_op ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod      = a_ext * b_ext;

    // Divide on magnitudes, then restore signs: quotient truncates toward zero and
    // the remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000, 0.
    a_neg   = signed_op & a_q[31];
    b_neg   = signed_op & b_q[31];
    a_mag   = a_neg ? (32'd0 - a_q) : a_q;
    b_mag   = b_neg ? (32'd0 - b_q) : b_q;
    divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem     = a_neg ? (32'd0 - r_mag) : r_mag;

    res_valid = 1'b0;
    res_hi    = hi_q;
    res_lo    = lo_q;
    case (op_q)
      OP_MULT, OP_MULTU: begin
        res_valid = 1'b1;
        {res_hi, res_lo} = prod;
      end
      OP_DIV, OP_DIVU: begin
        // Divide by zero still burns the full window but leaves HI/LO untouched.
        if (b_q != 32'd0) begin
          res_valid = 1'b1;
          res_hi    = rem;
          res_lo    = quot;
        end
      end
      default: res_valid = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path infers a latch.
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;

    if (busy) begin
      // Requests while busy, including one on the result edge itself, are dropped.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && res_valid) begin
        hi_d = res_hi;
        lo_d = res_lo;
      end
    end else if (start) begin
      case (req_op)
        OP_MULT, OP_MULTU: begin
          cnt_d = CNT_W'(MULT_CYCLES);
          op_d  = req_op;
          a_d   = a;
          b_d   = b;
        end
        OP_DIV, OP_DIVU: begin
          cnt_d = CNT_W'(DIV_CYCLES);
          op_d  = req_op;
          a_d   = a;
          b_d   = b;
        end
        OP_MTHI: hi_d = a;
        OP_MTLO: lo_d = a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      op_q  <= OP_NONE;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, corner-case sequences
// and randomized operations compared against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hi, m_lo;

  mul_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .stall (stall),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_long(input logic [2:0] o);
    return (o >= 3'd1) && (o <= 3'd4);
  endfunction

  function automatic int op_cycles(input logic [2:0] o);
    if (o == 3'd1 || o == 3'd2) return MULT_N;
    if (o == 3'd3 || o == 3'd4) return DIV_N;
    return 0;
  endfunction

  // Reference model: plain integer arithmetic on the architectural meaning of each op.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] cur_hi,
                                        input logic [31:0] cur_lo);
    longint          sp;
    longint unsigned up;
    int              sq, sr;
    case (o)
      3'd1: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        return sp;
      end
      3'd2: begin
        up = longint'({32'b0, x}) * longint'({32'b0, y});
        return up;
      end
      3'd3: begin
        if (y == 32'd0) return {cur_hi, cur_lo};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      3'd4: begin
        if (y == 32'd0) return {cur_hi, cur_lo};
        return {x % y, x / y};
      end
      3'd5: return {x, cur_lo};
      3'd6: return {cur_hi, x};
      default: return {cur_hi, cur_lo};
    endcase
  endfunction

  // Issue one request in an idle cycle, track busy length and HI/LO stability,
  // then compare against the supplied expected result.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int cycles;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    #1;
    check({name, ".stall_req"}, {31'b0, stall}, {31'b0, is_long(o)});
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    a = $urandom; b = $urandom;
    cycles = 0;
    if (is_long(o)) begin
      while (busy && cycles < 40) begin
        check({name, ".hi_hold"}, hi, m_hi);
        check({name, ".lo_hold"}, lo, m_lo);
        check({name, ".stall_busy"}, {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        cycles++;
      end
    end
    check({name, ".busy_cycles"}, cycles, op_cycles(o));
    check({name, ".busy_end"}, {31'b0, busy}, 32'd0);
    check({name, ".hi"}, hi, exp_hi);
    check({name, ".lo"}, lo, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  o;
    logic [31:0] x, y;
    logic [31:0] exp_hi, exp_lo;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int          cycles;
    logic [63:0] r;
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    bit          saw_2a;

    vecs.push_back('{"mthi",       3'd5, 32'h11,         32'h0,        32'h11,         32'h0});
    vecs.push_back('{"mtlo",       3'd6, 32'h22,         32'h0,        32'h11,         32'h22});
    vecs.push_back('{"divu_by0",   3'd4, 32'd7,          32'd0,        32'h11,         32'h22});
    vecs.push_back('{"div_by0",    3'd3, 32'd7,          32'd0,        32'h11,         32'h22});
    vecs.push_back('{"mult_neg",   3'd1, 32'hFFFF_FFFE,  32'd3,        32'hFFFF_FFFF,  32'hFFFF_FFFA});
    vecs.push_back('{"multu_max",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,32'hFFFF_FFFE,  32'h0000_0001});
    vecs.push_back('{"div_neg",    3'd3, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF,  32'hFFFF_FFFD});
    vecs.push_back('{"div_ovf",    3'd3, 32'h8000_0000,  32'hFFFF_FFFF,32'h0,          32'h8000_0000});
    vecs.push_back('{"divu_big",   3'd4, 32'hFFFF_FFFF,  32'd16,       32'hF,          32'h0FFF_FFFF});
    vecs.push_back('{"op_none",    3'd0, 32'd5,          32'd5,        32'hF,          32'h0FFF_FFFF});
    vecs.push_back('{"op_rsvd",    3'd7, 32'd5,          32'd5,        32'hF,          32'h0FFF_FFFF});
    vecs.push_back('{"div_negdiv", 3'd3, 32'd7,          32'hFFFF_FFFE,32'd1,          32'hFFFF_FFFD});
    vecs.push_back('{"mult_min",   3'd1, 32'h8000_0000,  32'h8000_0000,32'h4000_0000,  32'h0});

    start = 1'b0; op = 3'd0; a = '0; b = '0;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    #1;
    check("reset.hi", hi, 32'h0);
    check("reset.lo", lo, 32'h0);
    check("reset.busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].exp_hi, vecs[i].exp_lo);

    // Start ignored while busy (including on the result edge), accepted one edge later.
    run_op("pre_mtlo", 3'd6, 32'h55, 32'h0, m_hi, 32'h55);
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    cycles = 0;
    repeat (2) begin @(posedge clk); #1; cycles++; end
    start = 1'b1; op = 3'd5; a = 32'h1234;
    while (busy && cycles < 40) begin
      check("ign.stall", {31'b0, stall}, 32'd1);
      check("ign.hi_hold", hi, m_hi);
      @(posedge clk); #1;
      cycles++;
    end
    check("ign.busy_cycles", cycles, DIV_N);
    check("ign.hi_rem", hi, 32'd2);
    check("ign.lo_quot", lo, 32'd14);
    check("ign.stall_mthi", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    check("ign.mthi_after", hi, 32'h1234);
    check("ign.lo_kept", lo, 32'd14);
    check("ign.busy_mthi", {31'b0, busy}, 32'd0);
    m_hi = 32'h1234; m_lo = 32'd14;

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd7; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid.busy", {31'b0, busy}, 32'd0);
    check("rst_mid.hi", hi, 32'h0);
    check("rst_mid.lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    saw_2a = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (lo == 32'h2A || busy) saw_2a = 1'b1;
    end
    check("rst_mid.no_result", {31'b0, saw_2a}, 32'd0);
    m_hi = '0; m_lo = '0;

    // Randomized operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: ry = 32'hFFFF_FFFF;
        2: rx = 32'h8000_0000;
        3: ry = 32'($urandom_range(1, 9));
        default: ;
      endcase
      r = model(ro, rx, ry, m_hi, m_lo);
      run_op($sformatf("rand%0d", k), ro, rx, ry, r[63:32], r[31:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
